// File: rtl/finv.sv
// rtl/finv.sv - two-stage pipelined binary32 reciprocal (y = 1/x)
module finv (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    output logic [31:0] y
);

    typedef enum logic [1:0] {
        CLS_NUM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // 2^47 / {1,mant} yields 2/(1.m) scaled by 2^23, i.e. the normalized quotient.
    localparam logic [47:0] DIV_NUM = 48'h8000_0000_0000;

    logic        s1_sign_q, s1_sign_d;
    cls_e        s1_cls_q, s1_cls_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [23:0] s1_frac_q, s1_frac_d;
    logic        s1_rnd_q, s1_rnd_d;
    logic [31:0] y_q, y_d;

    logic [7:0]  ex;
    logic [22:0] mant;
    logic [47:0] den;
    logic [47:0] quo;
    logic [47:0] rem;
    logic [48:0] rem2;
    logic [9:0]  ey_raw;
    logic        unused_quo;

    assign unused_quo = ^quo[47:24];

    always_comb begin
        ex         = x[30:23];
        mant       = x[22:0];
        den        = {24'b0, 1'b1, mant};
        quo        = DIV_NUM / den;
        rem        = DIV_NUM % den;
        rem2       = {rem, 1'b0};
        s1_sign_d  = x[31];
        s1_cls_d   = CLS_NUM;
        s1_exp_d   = 8'd0;
        s1_frac_d  = 24'h800000;
        s1_rnd_d   = 1'b0;
        ey_raw     = (mant == 23'd0) ? (10'd254 - {2'b0, ex}) : (10'd253 - {2'b0, ex});

        if (ex == 8'd0) begin
            s1_cls_d = CLS_INF;
        end else if (ex == 8'hFF) begin
            s1_cls_d = (mant == 23'd0) ? CLS_ZERO : CLS_NAN;
        end else if (ey_raw[9] || (ey_raw == 10'd0)) begin
            // result would be denormal; flushed to signed zero
            s1_cls_d = CLS_ZERO;
        end else begin
            s1_exp_d = ey_raw[7:0];
            if (mant != 23'd0) begin
                s1_frac_d = quo[23:0];
                s1_rnd_d  = (rem2 > {1'b0, den}) || ((rem2 == {1'b0, den}) && quo[0]);
            end
        end
    end

    logic [24:0] frac_sum;

    always_comb begin
        frac_sum = {1'b0, s1_frac_q} + {24'b0, s1_rnd_q};
        y_d      = {s1_sign_q, 31'b0};
        case (s1_cls_q)
            CLS_NUM: begin
                // a rounding carry renormalizes: mantissa shifts right, exponent bumps
                if (frac_sum[24]) begin
                    y_d = {s1_sign_q, s1_exp_q + 8'd1, frac_sum[23:1]};
                end else begin
                    y_d = {s1_sign_q, s1_exp_q, frac_sum[22:0]};
                end
            end
            CLS_INF:  y_d = {s1_sign_q, 8'hFF, 23'b0};
            CLS_NAN:  y_d = {s1_sign_q, 8'hFF, 1'b1, 22'b0};
            default:  y_d = {s1_sign_q, 31'b0};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_sign_q <= 1'b0;
            s1_cls_q  <= CLS_ZERO;
            s1_exp_q  <= 8'd0;
            s1_frac_q <= 24'd0;
            s1_rnd_q  <= 1'b0;
            y_q       <= 32'h0;
        end else begin
            s1_sign_q <= s1_sign_d;
            s1_cls_q  <= s1_cls_d;
            s1_exp_q  <= s1_exp_d;
            s1_frac_q <= s1_frac_d;
            s1_rnd_q  <= s1_rnd_d;
            y_q       <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_finv.sv
// tb/tb_finv.sv - self-checking bench for finv against a real-arithmetic reference
module tb_finv;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x = 32'h0;
    logic [31:0] y;

    always #5 clk = ~clk;

    finv dut (
        .clk  (clk),
        .rstn (rstn),
        .x    (x),
        .y    (y)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: exact 1/x in double precision, rounded to binary32 by RNE.
    function automatic void model(input logic [31:0] xi, output logic [31:0] e,
                                  output int tol, output bit zexp);
        logic        s;
        logic [7:0]  ex;
        logic [22:0] m;
        real         xv, r;
        logic [63:0] db;
        int          ed;
        logic [22:0] keep;
        logic [28:0] rest;
        logic [30:0] val;
        bit          up;
        s    = xi[31];
        ex   = xi[30:23];
        m    = xi[22:0];
        tol  = 0;
        zexp = 1'b0;
        if (ex == 8'd0) begin
            e = {s, 8'hFF, 23'b0};
        end else if (ex == 8'hFF) begin
            e = (m == 23'd0) ? {s, 31'b0} : {s, 8'hFF, 1'b1, 22'b0};
        end else begin
            xv = (1.0 + real'(m) / 8388608.0) * (2.0 ** (real'(int'(ex)) - 127.0));
            r  = 1.0 / xv;
            db = $realtobits(r);
            ed = int'(db[62:52]) - 1023 + 127;
            if (ed <= 0) begin
                zexp = 1'b1;
                e    = {s, 31'b0};
            end else begin
                keep = db[51:29];
                rest = db[28:0];
                up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && keep[0]);
                val  = {ed[7:0], keep} + {30'b0, up};
                e    = {s, val};
                tol  = (m == 23'd0) ? 0 : 3;
            end
        end
    endfunction

    task automatic check_y(input string name, input logic [31:0] xi, input logic [31:0] ya,
                           input logic [31:0] e, input int tol, input bit zexp);
        bit     ok;
        longint d;
        n_checks++;
        if (zexp) begin
            ok = (ya[30:23] == 8'd0) && (ya[31] == e[31]);
        end else begin
            d = longint'(ya) - longint'(e);
            if (d < 0) d = -d;
            ok = (d <= longint'(tol));
        end
        if (!ok) begin
            n_fail++;
            $display("FAIL %s x=%h y=%h required=%h tol=%0d zexp=%0d", name, xi, ya, e, tol, zexp);
        end
    endtask

    // Delay line of accepted operands; async-cleared so in-flight work is forgotten on reset.
    logic [31:0] smp1, smp2;
    logic        v1, v2;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smp1 <= 32'h0; smp2 <= 32'h0; v1 <= 1'b0; v2 <= 1'b0;
        end else begin
            smp1 <= x; smp2 <= smp1; v1 <= 1'b1; v2 <= v1;
        end
    end

    logic [31:0] cmp_e;
    int          cmp_t;
    bit          cmp_z;
    always @(negedge clk) begin
        if (v2) begin
            model(smp2, cmp_e, cmp_t, cmp_z);
            check_y("pipe", smp2, y, cmp_e, cmp_t, cmp_z);
        end else begin
            check_y("idle_zero", smp2, y, 32'h0, 0, 1'b0);
        end
    end

    task automatic dir(input logic [31:0] v, input logic [31:0] e, input int tol);
        @(negedge clk);
        x = v;
        @(negedge clk);
        @(negedge clk);
        check_y("directed", v, y, e, tol, 1'b0);
    endtask

    typedef struct {
        logic [31:0] xv;
        logic [31:0] ev;
        int          tol;
    } vec_t;

    vec_t vecs[12] = '{
        '{32'h3F800000, 32'h3F800000, 0},
        '{32'h40000000, 32'h3F000000, 0},
        '{32'hBF000000, 32'hC0000000, 0},
        '{32'h40400000, 32'h3EAAAAAB, 3},
        '{32'h3FFFFFFF, 32'h3F000001, 3},
        '{32'h00800001, 32'h7E7FFFFE, 3},
        '{32'h7E800001, 32'h00000000, 0},
        '{32'hFF000000, 32'h80000000, 0},
        '{32'h00000000, 32'h7F800000, 0},
        '{32'h80000000, 32'hFF800000, 0},
        '{32'h7F800000, 32'h00000000, 0},
        '{32'h7FC00000, 32'h7FC00000, 0}
    };

    logic [22:0] mants[7] = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5FFFFF, 23'h7FFFFF};

    logic [31:0] pe;
    int          pt;
    bit          pz;

    initial begin
        // Pin the reference model itself to hand-computed values.
        model(32'h40400000, pe, pt, pz); check_y("model_3", 32'h40400000, pe, 32'h3EAAAAAB, 0, 1'b0);
        model(32'h3FFFFFFF, pe, pt, pz); check_y("model_max_m", 32'h3FFFFFFF, pe, 32'h3F000001, 0, 1'b0);
        model(32'h00800001, pe, pt, pz); check_y("model_min_e", 32'h00800001, pe, 32'h7E7FFFFE, 0, 1'b0);
        model(32'h3E800000, pe, pt, pz); check_y("model_quarter", 32'h3E800000, pe, 32'h40800000, 0, 1'b0);

        repeat (3) @(negedge clk);
        #1 check_y("reset_state", x, y, 32'h0, 0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) dir(vecs[i].xv, vecs[i].ev, vecs[i].tol);

        @(negedge clk); x = 32'h3F800000;
        @(negedge clk); x = 32'h40000000;
        @(negedge clk); check_y("stream_0", 32'h3F800000, y, 32'h3F800000, 0, 1'b0); x = 32'h40800000;
        @(negedge clk); check_y("stream_1", 32'h40000000, y, 32'h3F000000, 0, 1'b0);
        @(negedge clk); check_y("stream_2", 32'h40800000, y, 32'h3E800000, 0, 1'b0);

        x = 32'h40000000;
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_y("async_reset", x, y, 32'h0, 0, 1'b0);
        x = 32'h40800000;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #1 check_y("post_reset_hold", x, y, 32'h0, 0, 1'b0);
        @(negedge clk); #1 check_y("post_reset_first", x, y, 32'h3E800000, 0, 1'b0);

        for (int e = 1; e <= 253; e++) begin
            for (int s = 0; s < 2; s++) begin
                for (int k = 0; k < 10; k++) begin
                    logic [22:0] mm;
                    mm = (k < 7) ? mants[k] : 23'($urandom_range(0, 32'h7FFFFF));
                    @(negedge clk);
                    x = {s[0], e[7:0], mm};
                end
            end
        end
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
